// File: rtl/game_pkg.sv
// game_pkg: shared types for the game input blocks
package game_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, REL_CHK} btn_state;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: synchronizes one raw button, debounces it and emits a press pulse and held level
module button_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press,
  output logic held
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  logic s;
  btn_state state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic press_q, press_d, held_q, held_d;
  assign s = sync_q[1];
  assign press = press_q;
  assign held = held_q;
  // two-flop synchronizer for the possibly asynchronous raw level
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], raw};
  // state, counter and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      held_q  <= held_d;
    end
  // next state: a level change must persist for DEBOUNCE_CYCLES samples to be accepted
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:      if (s) begin state_d = PRESS_CHK; cnt_d = '0; end
      PRESS_CHK: if (!s) state_d = IDLE;
                 else if (cnt_q == LAST) state_d = PRESSED;
                 else cnt_d = cnt_q + 1'b1;
      PRESSED:   if (!s) begin state_d = REL_CHK; cnt_d = '0; end
      REL_CHK:   if (s) state_d = PRESSED;
                 else if (cnt_q == LAST) state_d = IDLE;
                 else cnt_d = cnt_q + 1'b1;
      default:   state_d = IDLE;
    endcase
  end
  // outputs: pulse only on an accepted press, held while pressed or checking a release
  always_comb begin
    press_d = (state_q == PRESS_CHK) && (state_d == PRESSED);
    held_d  = (state_d == PRESSED) || (state_d == REL_CHK);
  end
endmodule

// File: rtl/mouse_click_gen.sv
// mouse_click_gen: debounced click pulses and held levels for both mouse buttons
module mouse_click_gen
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst,
  input  logic left_raw,
  input  logic right_raw,
  output logic mouse_left,
  output logic mouse_right,
  output logic left_held,
  output logic right_held
);
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk(clk), .rst(rst), .raw(left_raw), .press(mouse_left), .held(left_held)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk(clk), .rst(rst), .raw(right_raw), .press(mouse_right), .held(right_held)
  );
endmodule
